// File: rtl/ifu.sv
// Instruction fetch unit: owns the program counter and selects the next
// fetch address each cycle from stall, jump, branch and sequential sources.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        beq,
    input  logic        bneq,
    input  logic        bge,
    input  logic        ble,
    input  logic        jump,
    input  logic [31:0] immi_address,
    input  logic [31:0] immi_address_jump,
    output logic [31:0] pc
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        w_branch_taken;

    // Several branch flags at once still describe one taken branch.
    assign w_branch_taken = beq | bneq | bge | ble;

    // Next-PC selection: stall holds, jump beats branch, otherwise step.
    // Adds wrap modulo 2^32; misaligned targets pass through unchanged.
    always_comb begin
        w_pc_next = r_pc + 32'(PC_STEP);
        if (stall) begin
            w_pc_next = r_pc;
        end else if (jump) begin
            w_pc_next = r_pc + immi_address_jump;
        end else if (w_branch_taken) begin
            w_pc_next = r_pc + immi_address;
        end
    end

    // PC register; reset takes effect immediately, without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a directed vector table, hand-written
// wrap/asynchronous-reset sequences, and randomized traffic against a model.
module tb_ifu;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        beq;
    logic        bneq;
    logic        bge;
    logic        ble;
    logic        jump;
    logic [31:0] immi_address;
    logic [31:0] immi_address_jump;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    ifu #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .beq              (beq),
        .bneq             (bneq),
        .bge              (bge),
        .ble              (ble),
        .jump             (jump),
        .immi_address     (immi_address),
        .immi_address_jump(immi_address_jump),
        .pc               (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        beq;
        logic        bneq;
        logic        bge;
        logic        ble;
        logic        jump;
        logic [31:0] imm;
        logic [31:0] immj;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic s, input logic b0, input logic b1,
                                input logic b2, input logic b3, input logic j,
                                input logic [31:0] imm, input logic [31:0] immj,
                                input logic [31:0] e);
        vec_t v;
        v.stall = s; v.beq = b0; v.bneq = b1; v.bge = b2; v.ble = b3; v.jump = j;
        v.imm = imm; v.immj = immj; v.exp_pc = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: pc=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b0, input logic b1, input logic b2,
                         input logic b3, input logic j, input logic [31:0] imm,
                         input logic [31:0] immj);
        stall = s; beq = b0; bneq = b1; bge = b2; ble = b3; jump = j;
        immi_address = imm; immi_address_jump = immj;
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic s, input logic b0, input logic b1, input logic b2,
                        input logic b3, input logic j, input logic [31:0] imm,
                        input logic [31:0] immj);
        drive(s, b0, b1, b2, b3, j, imm, immj);
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] model_pc;
        logic        r_s, r_j, r_b0, r_b1, r_b2, r_b3;
        logic [31:0] r_imm, r_immj;

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, '0, '0);

        // Directed sequence starting from pc = 0 after reset release.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0004);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0008);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 32'h4,        32'h0,        32'h0000_000C);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0010);
        vecs[4]  = mk(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,       32'h0000_0008);
        vecs[5]  = mk(0, 0, 0, 1, 0, 0, 32'h4,        32'h0,        32'h0000_000C);
        vecs[6]  = mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h2,        32'h0000_000E);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0012);
        vecs[8]  = mk(0, 1, 0, 0, 0, 1, 32'h4,        32'h40,       32'h0000_0052);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFE, 32'h0,       32'h0000_0050);
        vecs[10] = mk(0, 0, 1, 1, 0, 0, 32'h10,       32'h0,        32'h0000_0060);
        vecs[11] = mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h100,      32'h0000_0060);
        vecs[12] = mk(1, 1, 0, 0, 0, 0, 32'h100,      32'h0,        32'h0000_0060);
        vecs[13] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0060);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0064);

        // Reset state, including across edges while reset is held.
        #1;
        check("reset_async", pc, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", pc, 32'h0);
        step(0, 1, 0, 0, 0, 1, 32'h44, 32'h88);
        check("reset_hold_redirect", pc, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].stall, vecs[i].beq, vecs[i].bneq, vecs[i].bge, vecs[i].ble,
                 vecs[i].jump, vecs[i].imm, vecs[i].immj);
            check($sformatf("vec%0d", i), pc, vecs[i].exp_pc);
        end

        // Wrap-around: land on 0xFFFF_FFFC then step to 0.
        step(0, 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC - 32'h64);
        check("wrap_setup", pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("wrap_zero", pc, 32'h0);

        // Asynchronous reset mid-cycle with a jump pending.
        step(0, 0, 0, 0, 0, 1, 32'h0, 32'h30);
        check("async_setup", pc, 32'h30);
        drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h100);
        #2 reset = 1'b1;
        #1;
        check("async_reset_immediate", pc, 32'h0);
        @(posedge clk);
        #1;
        check("async_reset_hold", pc, 32'h0);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("restart_4", pc, 32'h4);

        // Randomized traffic against the priority-rule model.
        model_pc = 32'h4;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                drive(1'($urandom), 1'($urandom), 0, 0, 0, 1'($urandom), $urandom, $urandom);
                #3 reset = 1'b1;
                #1;
                model_pc = 32'h0;
                check("rand_async_reset", pc, model_pc);
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else begin
                r_s  = ($urandom_range(0, 5) == 0);
                r_j  = ($urandom_range(0, 4) == 0);
                r_b0 = ($urandom_range(0, 5) == 0);
                r_b1 = ($urandom_range(0, 5) == 0);
                r_b2 = ($urandom_range(0, 5) == 0);
                r_b3 = ($urandom_range(0, 5) == 0);
                r_imm  = $urandom;
                r_immj = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    r_imm  = 32'($signed(32'($urandom_range(0, 64))) - 32);
                    r_immj = 32'($signed(32'($urandom_range(0, 64))) - 32);
                end
                step(r_s, r_b0, r_b1, r_b2, r_b3, r_j, r_imm, r_immj);
                if (r_s)                          model_pc = model_pc;
                else if (r_j)                     model_pc = model_pc + r_immj;
                else if (r_b0 | r_b1 | r_b2 | r_b3) model_pc = model_pc + r_imm;
                else                              model_pc = model_pc + 32'd4;
                check("random", pc, model_pc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
